// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the hazard control unit: FSM state encoding and the
// stage-control bundle driven into the pipeline.
package hazard_control_unit_pkg;

  localparam int unsigned NB_REG_ADDR_DEFAULT  = 5;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_HALT_DRAIN = 2'd2,
    ST_HALTED     = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_en;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF    = '0;
  localparam ctrl_t CTRL_RUN    = ctrl_t'(5'b11001);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(5'b11101);
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(5'b00011);
  localparam ctrl_t CTRL_HALT   = ctrl_t'(5'b00001);

endpackage

// File: rtl/hazard_control_unit_load_use_detector.sv
// Load-use hazard compare: a load in EX whose destination is read by the ID
// instruction and cannot be covered by forwarding.
module load_use_detector #(
  parameter int unsigned NB_REG_ADDR = 5
) (
  input  logic                   i_mem_read_ex,
  input  logic [NB_REG_ADDR-1:0] i_rd_ex,
  input  logic [NB_REG_ADDR-1:0] i_rs_id,
  input  logic [NB_REG_ADDR-1:0] i_rt_id,
  input  logic                   i_use_rt_id,
  output logic                   o_load_use
);

  always_comb begin
    o_load_use = i_mem_read_ex && (i_rd_ex != '0) &&
                 ((i_rd_ex == i_rs_id) || (i_use_rt_id && (i_rd_ex == i_rt_id)));
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stall, memory-wait freeze, branch flush, HALT drain.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned NB_REG_ADDR  = NB_REG_ADDR_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int unsigned NB_PERF_CNT  = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_mem_read_ex,
  input  logic [NB_REG_ADDR-1:0] i_rd_ex,
  input  logic [NB_REG_ADDR-1:0] i_rs_id,
  input  logic [NB_REG_ADDR-1:0] i_rt_id,
  input  logic                   i_use_rt_id,
  input  logic                   i_mem_req,
  input  logic                   i_mem_ready,
  input  logic                   i_branch_taken,
  input  logic                   i_halt_id,
  output logic                   o_pc_we,
  output logic                   o_if_id_we,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_bubble,
  output logic                   o_pipe_en,
  output logic                   o_halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [NB_PERF_CNT-1:0] o_stall_cycles,
  output logic [NB_PERF_CNT-1:0] o_flush_count
`endif
);

  localparam int unsigned NB_CNT = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DRAIN_CYCLES - 1);

  state_t            state, next_state;
  logic [NB_CNT-1:0] cnt, next_cnt;
  ctrl_t             ctrl;
  logic              load_use;
  logic              mem_wait;

  load_use_detector #(
    .NB_REG_ADDR (NB_REG_ADDR)
  ) u_load_use_detector (
    .i_mem_read_ex (i_mem_read_ex),
    .i_rd_ex       (i_rd_ex),
    .i_rs_id       (i_rs_id),
    .i_rt_id       (i_rt_id),
    .i_use_rt_id   (i_use_rt_id),
    .o_load_use    (load_use)
  );

  assign mem_wait = i_mem_req && !i_mem_ready;

  always_comb begin
    ctrl       = CTRL_OFF;
    next_state = state;
    next_cnt   = cnt;
    if (i_reset && i_valid && (state != ST_HALTED) && !mem_wait) begin
      unique case (state)
        ST_RUN, ST_LOAD_STALL: begin
          next_state = ST_RUN;
          // HALT is also honoured from LOAD_STALL so it is never lost when it
          // reaches ID while the load bubble is being released.
          if ((state == ST_RUN) && load_use) begin
            ctrl       = CTRL_BUBBLE;
            next_state = ST_LOAD_STALL;
          end else if (i_halt_id) begin
            ctrl       = CTRL_HALT;
            next_state = ST_HALT_DRAIN;
            next_cnt   = '0;
          end else if (i_branch_taken) begin
            ctrl = CTRL_FLUSH;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
        ST_HALT_DRAIN: begin
          ctrl = CTRL_BUBBLE;
          if (cnt == CNT_LAST) next_state = ST_HALTED;
          else                 next_cnt   = cnt + NB_CNT'(1);
        end
        default: ctrl = CTRL_OFF;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_RUN;
      cnt      <= '0;
      o_halted <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      o_halted <= (next_state == ST_HALTED);
    end
  end

  assign o_pc_we        = ctrl.pc_we;
  assign o_if_id_we     = ctrl.if_id_we;
  assign o_if_id_flush  = ctrl.if_id_flush;
  assign o_id_ex_bubble = ctrl.id_ex_bubble;
  assign o_pipe_en      = ctrl.pipe_en;

`ifdef HAZARD_PERF_EN
  logic count_stall;
  assign count_stall = i_valid && !ctrl.pc_we &&
                       ((state == ST_RUN) || (state == ST_LOAD_STALL));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
    end else begin
      if (count_stall && (o_stall_cycles != '1))
        o_stall_cycles <= o_stall_cycles + NB_PERF_CNT'(1);
      if (i_valid && ctrl.if_id_flush && (o_flush_count != '1))
        o_flush_count <= o_flush_count + NB_PERF_CNT'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit; expected control vectors
// are queued per step and compared at the following falling edge.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n, vld, mr, urt, req, rdy, br, hlt;
  logic [4:0] rd, rs, rt;
  logic       pc_we, if_id_we, flush, bubble, pipe_en, halted;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(
    .NB_REG_ADDR  (5),
    .DRAIN_CYCLES (3),
    .NB_PERF_CNT  (32)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_valid        (vld),
    .i_mem_read_ex  (mr),
    .i_rd_ex        (rd),
    .i_rs_id        (rs),
    .i_rt_id        (rt),
    .i_use_rt_id    (urt),
    .i_mem_req      (req),
    .i_mem_ready    (rdy),
    .i_branch_taken (br),
    .i_halt_id      (hlt),
    .o_pc_we        (pc_we),
    .o_if_id_we     (if_id_we),
    .o_if_id_flush  (flush),
    .o_id_ex_bubble (bubble),
    .o_pipe_en      (pipe_en),
    .o_halted       (halted)
`ifdef HAZARD_PERF_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count)
`endif
  );

  typedef struct {
    logic [5:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passes = 0;

  // {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_en, halted}
  localparam logic [5:0] E_OFF    = 6'b000000;
  localparam logic [5:0] E_RUN    = 6'b110010;
  localparam logic [5:0] E_FLUSH  = 6'b111010;
  localparam logic [5:0] E_BUBBLE = 6'b000110;
  localparam logic [5:0] E_HALT   = 6'b000010;
  localparam logic [5:0] E_HALTED = 6'b000001;

  task automatic step(input string tag, input logic r, input logic v,
                      input logic m, input int d, input int s, input int t,
                      input logic u, input logic rq, input logic ry,
                      input logic b, input logic h, input logic [5:0] e);
    exp_t x;
    logic [5:0] obs;
    rst_n = r; vld = v; mr = m; rd = 5'(d); rs = 5'(s); rt = 5'(t);
    urt = u; req = rq; rdy = ry; br = b; hlt = h;
    q.push_back('{e, tag});
    @(negedge clk);
    x   = q.pop_front();
    obs = {pc_we, if_id_we, flush, bubble, pipe_en, halted};
    total++;
    assert (obs === x.v) passes++;
    else $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    //   tag               rst vld mr rd rs rt urt req rdy br hlt expected
    step("reset",          0,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_OFF);
    step("run_idle",       1,  1,  0, 0, 1, 2, 1,  0,  1,  0, 0,  E_RUN);
    step("lu_rs",          1,  1,  1, 3, 3, 4, 1,  0,  1,  0, 0,  E_BUBBLE);
    step("ls_ignores_lu",  1,  1,  1, 3, 3, 4, 1,  0,  1,  0, 0,  E_RUN);
    step("no_2nd_bubble",  1,  1,  0, 0, 3, 4, 1,  0,  1,  0, 0,  E_RUN);
    step("lu_r0",          1,  1,  1, 0, 0, 0, 1,  0,  1,  0, 0,  E_RUN);
    step("lu_rt",          1,  1,  1, 7, 2, 7, 1,  0,  1,  0, 0,  E_BUBBLE);
    step("lu_rt_release",  1,  1,  0, 0, 2, 7, 1,  0,  1,  0, 0,  E_RUN);
    step("rt_unused",      1,  1,  1, 7, 2, 7, 0,  0,  1,  0, 0,  E_RUN);
    for (int i = 0; i < 4; i++)
      step("memwait",      1,  1,  1, 3, 3, 4, 1,  1,  0,  0, 0,  E_OFF);
    step("lu_after_wait",  1,  1,  1, 3, 3, 4, 1,  1,  1,  0, 0,  E_BUBBLE);
    step("memwait_ls",     1,  1,  0, 0, 3, 4, 1,  1,  0,  0, 0,  E_OFF);
    step("ls_after_wait",  1,  1,  0, 0, 3, 4, 1,  0,  1,  0, 0,  E_RUN);
    step("valid0",         1,  0,  1, 3, 3, 4, 1,  0,  1,  1, 0,  E_OFF);
    step("valid0_held",    1,  1,  0, 0, 3, 4, 1,  0,  1,  0, 0,  E_RUN);
    step("br_run",         1,  1,  0, 0, 1, 2, 1,  0,  1,  1, 0,  E_FLUSH);
    step("br_lu",          1,  1,  1, 5, 5, 2, 1,  0,  1,  1, 0,  E_BUBBLE);
    step("br_after_lu",    1,  1,  0, 0, 5, 2, 1,  0,  1,  1, 0,  E_FLUSH);
    step("br_memwait",     1,  1,  0, 0, 1, 2, 1,  1,  0,  1, 0,  E_OFF);
    step("halt_run",       1,  1,  0, 0, 0, 0, 0,  0,  1,  0, 1,  E_HALT);
    step("drain0",         1,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_BUBBLE);
    step("drain_memwait",  1,  1,  0, 0, 0, 0, 0,  1,  0,  0, 0,  E_OFF);
    step("drain1",         1,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_BUBBLE);
    step("drain2",         1,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_BUBBLE);
    step("halted",         1,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_HALTED);
    step("halted_br",      1,  1,  1, 3, 3, 3, 1,  0,  1,  1, 0,  E_HALTED);
    step("halted_reset",   0,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_OFF);
    step("run_after_hlt",  1,  1,  0, 0, 1, 2, 1,  0,  1,  0, 0,  E_RUN);
    step("halt_again",     1,  1,  0, 0, 0, 0, 0,  0,  1,  0, 1,  E_HALT);
    step("drain_a0",       1,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_BUBBLE);
    step("rst_mid_drain",  0,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_OFF);
    step("run_after_rst",  1,  1,  0, 0, 1, 2, 1,  0,  1,  0, 0,  E_RUN);
    step("run_no_drain",   1,  1,  0, 0, 1, 2, 1,  0,  1,  0, 0,  E_RUN);

`ifdef HAZARD_PERF_EN
    step("perf_reset",     0,  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,  E_OFF);
    check_val("stall_rst", stall_cycles, 32'd0);
    check_val("flush_rst", flush_count, 32'd0);
    step("perf_lu1",       1,  1,  1, 3, 3, 4, 1,  0,  1,  0, 0,  E_BUBBLE);
    step("perf_ls1",       1,  1,  0, 0, 3, 4, 1,  0,  1,  0, 0,  E_RUN);
    step("perf_lu2",       1,  1,  1, 6, 1, 6, 1,  0,  1,  0, 0,  E_BUBBLE);
    step("perf_ls2_br",    1,  1,  0, 0, 1, 6, 1,  0,  1,  1, 0,  E_FLUSH);
    step("perf_idle",      1,  1,  0, 0, 1, 2, 1,  0,  1,  0, 0,  E_RUN);
    check_val("stall_cnt", stall_cycles, 32'd2);
    check_val("flush_cnt", flush_count, 32'd1);
    step("perf_v0a",       1,  0,  1, 3, 3, 4, 1,  0,  1,  1, 0,  E_OFF);
    step("perf_v0b",       1,  0,  1, 3, 3, 4, 1,  0,  1,  1, 0,  E_OFF);
    check_val("stall_hold", stall_cycles, 32'd2);
    check_val("flush_hold", flush_count, 32'd1);
`endif

    total++;
    assert (q.size() == 0) passes++;
    else $error("FAIL scoreboard_empty: observed %0d expected 0", q.size());

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
